// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic (write and read sides).
package fifo_pkg;

    localparam int GRAY_W_MAX = 16;

    typedef enum logic {
        WS_READY = 1'b0,
        WS_FULL  = 1'b1
    } ws_state_t;

    // Callers zero-extend into GRAY_W_MAX and truncate the result; upper zeros stay zero.
    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_write_logic_if.sv
// Write-side FIFO signals: producer request, synchronised read pointer, and status/RAM outputs.
interface fifo_write_logic_if #(
    parameter int PTR_SZ = 2
) ();
    logic              winc;
    logic [PTR_SZ:0]   wq2_raddr;
    logic              wfull;
    logic              write_en;
    logic [PTR_SZ-1:0] waddr;
    logic [PTR_SZ:0]   waddr_gray;
    logic [PTR_SZ:0]   wlevel;
    logic              wovf;

    modport master (
        output winc, wq2_raddr,
        input  wfull, write_en, waddr, waddr_gray, wlevel, wovf
    );

    modport slave (
        input  winc, wq2_raddr,
        output wfull, write_en, waddr, waddr_gray, wlevel, wovf
    );
endinterface

// File: rtl/fifo_write_logic.sv
// Write-side control of the dual-clock FIFO: write pointer, Gray publication, full/level/overflow.
//   state    | meaning
//   WS_READY | space available, writes accepted
//   WS_FULL  | post-write pointer meets read pointer one lap behind; writes blocked
module fifo_write_logic
    import fifo_pkg::*;
#(
    parameter int PTR_SZ = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_write_logic_if.slave  wif
);
    localparam int PTR_W = PTR_SZ + 1;

    ws_state_t        r_state;
    ws_state_t        w_state_next;
    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] r_level;
    logic             r_ovf;

    logic             w_write_en;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_rq_lap;
    logic [PTR_W-1:0] w_rbin;
    logic             w_full_hit;

    assign w_write_en  = wif.winc & (r_state != WS_FULL) & ~rst;
    assign w_bin_next  = r_bin + PTR_W'(w_write_en);
    assign w_gray_next = PTR_W'(bin2gray(GRAY_W_MAX'(w_bin_next)));
    assign w_rbin      = PTR_W'(gray2bin(GRAY_W_MAX'(wif.wq2_raddr)));

    // In Gray code, "one lap ahead" means the top two bits inverted, the rest equal.
    assign w_rq_lap   = {~wif.wq2_raddr[PTR_SZ:PTR_SZ-1], wif.wq2_raddr[PTR_SZ-2:0]};
    assign w_full_hit = (w_gray_next == w_rq_lap);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WS_READY: if (w_full_hit)  w_state_next = WS_FULL;
            WS_FULL:  if (!w_full_hit) w_state_next = WS_READY;
            default:  w_state_next = WS_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WS_READY;
            r_bin   <= '0;
            r_gray  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_level <= w_bin_next - w_rbin;
            if (wif.winc && (r_state == WS_FULL)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign wif.write_en   = w_write_en;
    assign wif.wfull      = (r_state == WS_FULL);
    assign wif.waddr      = r_bin[PTR_SZ-1:0];
    assign wif.waddr_gray = r_gray;
    assign wif.wlevel     = r_level;
    assign wif.wovf       = r_ovf;

endmodule

// File: tb/tb_fifo_write_logic.sv
// Directed bench for fifo_write_logic (PTR_SZ=2) with a fill-level reference model and scoreboard.
module tb_fifo_write_logic;

    localparam int PTR_SZ = 2;

    typedef struct packed {
        logic [1:0] waddr;
        logic [2:0] gray;
        logic       full;
        logic [2:0] level;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_write_logic_if #(.PTR_SZ(PTR_SZ)) wif ();

    fifo_write_logic #(.PTR_SZ(PTR_SZ)) dut (
        .clk (clk),
        .rst (rst),
        .wif (wif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // reference model state: binary pointer, full flag, sticky overflow
    int   m_bin  = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return int'(b);
    endfunction

    // One clock: drive inputs, check write_en, push model prediction, pop and compare after edge.
    task automatic step(input logic i_w, input logic [2:0] i_rq, input logic i_r);
        exp_t e;
        exp_t got;
        logic we;
        int   lvl;
        int   nb;
        @(negedge clk);
        wif.winc      = i_w;
        wif.wq2_raddr = i_rq;
        rst           = i_r;
        #1;
        we = i_w && !m_full && !i_r;
        check("write_en", {7'd0, wif.write_en}, {7'd0, we});
        if (i_r) begin
            m_bin = 0; m_full = 1'b0; m_ovf = 1'b0; lvl = 0;
        end else begin
            if (i_w && m_full) m_ovf = 1'b1;
            nb     = (m_bin + (we ? 1 : 0)) % 8;
            lvl    = (nb - g2b(i_rq) + 8) % 8;
            m_full = (lvl == 4);
            m_bin  = nb;
        end
        e.waddr = 2'(m_bin % 4);
        e.gray  = 3'(m_bin ^ (m_bin >> 1));
        e.full  = m_full;
        e.level = 3'(lvl);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("waddr",      {6'd0, wif.waddr},      {6'd0, got.waddr});
        check("waddr_gray", {5'd0, wif.waddr_gray}, {5'd0, got.gray});
        check("wfull",      {7'd0, wif.wfull},      {7'd0, got.full});
        check("wlevel",     {5'd0, wif.wlevel},     {5'd0, got.level});
        check("wovf",       {7'd0, wif.wovf},       {7'd0, got.ovf});
    endtask

    initial begin
        logic [2:0] prev_gray;
        wif.winc      = 1'b1;
        wif.wq2_raddr = 3'b000;

        // reset with winc held high
        step(1'b1, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b1);
        check("rst_waddr", {6'd0, wif.waddr}, 8'd0);
        check("rst_gray",  {5'd0, wif.waddr_gray}, 8'd0);

        // fill
        step(1'b1, 3'b000, 1'b0);
        check("fill_gray1", {5'd0, wif.waddr_gray}, 8'b001);
        step(1'b1, 3'b000, 1'b0);
        check("fill_gray2", {5'd0, wif.waddr_gray}, 8'b011);
        step(1'b1, 3'b000, 1'b0);
        check("fill_gray3", {5'd0, wif.waddr_gray}, 8'b010);
        check("fill_notfull3", {7'd0, wif.wfull}, 8'd0);
        step(1'b1, 3'b000, 1'b0);
        check("fill_gray4", {5'd0, wif.waddr_gray}, 8'b110);
        check("fill_full",  {7'd0, wif.wfull}, 8'd1);
        check("fill_level", {5'd0, wif.wlevel}, 8'd4);
        check("fill_waddr", {6'd0, wif.waddr}, 8'd0);

        // overflow attempt while full
        step(1'b1, 3'b000, 1'b0);
        check("ovf_gray", {5'd0, wif.waddr_gray}, 8'b110);
        check("ovf_set",  {7'd0, wif.wovf}, 8'd1);
        step(1'b0, 3'b000, 1'b0);
        check("ovf_sticky", {7'd0, wif.wovf}, 8'd1);

        // drain release then refill
        step(1'b0, 3'b001, 1'b0);
        check("drain_full",  {7'd0, wif.wfull}, 8'd0);
        check("drain_level", {5'd0, wif.wlevel}, 8'd3);
        step(1'b1, 3'b001, 1'b0);
        check("refill_full", {7'd0, wif.wfull}, 8'd1);
        check("refill_gray", {5'd0, wif.waddr_gray}, 8'b111);
        check("refill_ovf",  {7'd0, wif.wovf}, 8'd1);

        step(1'b0, 3'b000, 1'b1);
        check("ovf_cleared", {7'd0, wif.wovf}, 8'd0);

        // wrap with reads keeping pace: read pointer = gray(wbin-1)
        prev_gray = wif.waddr_gray;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] rb;
            rb = 3'((i + 7) % 8);
            step(1'b1, rb ^ (rb >> 1), 1'b0);
            check("wrap_waddr", {6'd0, wif.waddr}, 8'((i + 1) % 4));
            check("wrap_nofull", {7'd0, wif.wfull}, 8'd0);
            check("wrap_gray1bit", 8'($countones(wif.waddr_gray ^ prev_gray)), 8'd1);
            prev_gray = wif.waddr_gray;
        end

        // reset mid-operation
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        check("mid_waddr3", {6'd0, wif.waddr}, 8'd3);
        step(1'b1, 3'b000, 1'b1);
        check("mid_rst_waddr", {6'd0, wif.waddr}, 8'd0);
        check("mid_rst_gray",  {5'd0, wif.waddr_gray}, 8'd0);
        check("mid_rst_level", {5'd0, wif.wlevel}, 8'd0);
        check("mid_rst_full",  {7'd0, wif.wfull}, 8'd0);
        check("mid_rst_ovf",   {7'd0, wif.wovf}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
